// File: rtl/sdram_pkg.sv
// Types shared by the SDRAM controller and its line-cache client.
// Burst word 0 is the most significant 16 bits of the 64-bit burst.
package sdram_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIT,
    S_FILL_REQ,
    S_FILL_GUARD,
    S_FILL_WAIT,
    S_WR_REQ,
    S_WR_GUARD,
    S_WR_WAIT
  } cache_state_t;

  localparam logic SD_BURST4 = 1'b1;
  localparam int   WORD_W    = 16;
  localparam int   BURST_W   = 64;

  function automatic logic [WORD_W-1:0] burst_word(
    input logic [BURST_W-1:0] line,
    input logic [1:0]         w
  );
    logic [WORD_W-1:0] r;
    unique case (w)
      2'd0: r = line[63:48];
      2'd1: r = line[47:32];
      2'd2: r = line[31:16];
      default: r = line[15:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sdram_line_store.sv
// Direct-mapped line array: 64-bit data, tag and valid per line.
// Combinational read, burst fill port and byte-merge word write port.
module sdram_line_store
  import sdram_pkg::*;
#(
  parameter int LINE_BITS = 2,
  parameter int TAG_W     = 20
) (
  input  logic                 clk,
  input  logic                 init,
  input  logic                 flush,
  input  logic                 fill_en,
  input  logic [LINE_BITS-1:0] fill_idx,
  input  logic [BURST_W-1:0]   fill_data,
  input  logic [TAG_W-1:0]     fill_tag,
  input  logic                 fill_valid,
  input  logic                 wr_en,
  input  logic [LINE_BITS-1:0] wr_idx,
  input  logic [1:0]           wr_word,
  input  logic [1:0]           wr_be,
  input  logic [WORD_W-1:0]    wr_data,
  input  logic [LINE_BITS-1:0] rd_idx,
  output logic [BURST_W-1:0]   rd_data,
  output logic [TAG_W-1:0]     rd_tag,
  output logic                 rd_valid
);

  localparam int LINES = 1 << LINE_BITS;

  logic [BURST_W-1:0] data [LINES];
  logic [TAG_W-1:0]   tags [LINES];
  logic [LINES-1:0]   valid;

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      valid <= '0;
    end else begin
      if (flush)
        valid <= '0;
      if (fill_en)
        valid[fill_idx] <= fill_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      data[fill_idx] <= fill_data;
      tags[fill_idx] <= fill_tag;
    end
    if (wr_en) begin
      for (int w = 0; w < 4; w++) begin
        if (wr_word == w[1:0]) begin
          if (wr_be[1])
            data[wr_idx][63-16*w -: 8] <= wr_data[15:8];
          if (wr_be[0])
            data[wr_idx][55-16*w -: 8] <= wr_data[7:0];
        end
      end
    end
  end

  assign rd_data  = data[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_valid = valid[rd_idx];

endmodule

// File: rtl/sdram_line_cache.sv
// CPU-side direct-mapped read cache with write-through, driving the
// SDRAM controller request port (burst fills, single-word writes).
module sdram_line_cache
  import sdram_pkg::*;
#(
  parameter int AW        = 25,
  parameter int LINE_BITS = 2,
  parameter int GUARD     = 2
) (
  input  logic              clk,
  input  logic              init,
  input  logic              flush,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [15:0]       cpu_din,
  input  logic [1:0]        cpu_wtbt,
  output logic [15:0]       cpu_dout,
  output logic              cpu_ack,
  output logic [AW-1:0]     sd_addr,
  output logic [15:0]       sd_din,
  output logic [1:0]        sd_wtbt,
  output logic              sd_rd,
  output logic              sd_we,
  output logic              sd_rd_type,
  input  logic [63:0]       sd_dout,
  input  logic              sd_ready
);

  localparam int TAG_W = AW - 3 - LINE_BITS;
  localparam int CW    = $clog2(GUARD + 2);

  cache_state_t state, state_nx;

  logic                 rd_q, wr_q, rd_req, wr_req;
  logic                 flush_seen;
  logic [CW-1:0]        cnt;
  logic [1:0]           word;
  logic [LINE_BITS-1:0] idx;
  logic [TAG_W-1:0]     tag;
  logic [63:0]          line_data;
  logic [TAG_W-1:0]     line_tag;
  logic                 line_valid, hit;
  logic                 fill_en, wr_en;
  logic [1:0]           wr_be;
  logic [15:0]          wr_data;
  logic                 in_fill;

  assign word    = cpu_addr[2:1];
  assign idx     = cpu_addr[2+LINE_BITS:3];
  assign tag     = cpu_addr[AW-1:3+LINE_BITS];
  assign hit     = line_valid && (line_tag == tag);
  assign in_fill = (state == S_FILL_REQ) || (state == S_FILL_GUARD) ||
                   (state == S_FILL_WAIT);

  assign sd_rd_type = SD_BURST4;

  // Byte write without enables: addr[0] picks the lane (big-endian).
  always_comb begin
    wr_be   = cpu_wtbt;
    wr_data = cpu_din;
    if (cpu_wtbt == 2'b00) begin
      wr_be   = cpu_addr[0] ? 2'b01 : 2'b10;
      wr_data = {cpu_din[7:0], cpu_din[7:0]};
    end
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state      <= S_IDLE;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      rd_req     <= 1'b0;
      wr_req     <= 1'b0;
      flush_seen <= 1'b0;
      cnt        <= '0;
    end else begin
      state  <= state_nx;
      rd_q   <= cpu_rd;
      wr_q   <= cpu_wr;
      rd_req <= cpu_rd & ~rd_q;
      wr_req <= cpu_wr & ~wr_q;
      if (state == S_FILL_REQ || state == S_WR_REQ)
        cnt <= CW'(GUARD);
      else if (cnt != '0)
        cnt <= cnt - 1'b1;
      if (state == S_IDLE)
        flush_seen <= 1'b0;
      else if (flush && in_fill)
        flush_seen <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (wr_req)
          state_nx = S_WR_REQ;
        else if (rd_req)
          state_nx = hit ? S_HIT : S_FILL_REQ;
      end
      S_HIT:        state_nx = S_IDLE;
      S_FILL_REQ:   state_nx = S_FILL_GUARD;
      S_FILL_GUARD: if (cnt == '0) state_nx = S_FILL_WAIT;
      S_FILL_WAIT:  if (sd_ready) state_nx = S_IDLE;
      S_WR_REQ:     state_nx = S_WR_GUARD;
      S_WR_GUARD:   if (cnt == '0) state_nx = S_WR_WAIT;
      S_WR_WAIT:    if (sd_ready) state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_dout = '0;
    cpu_ack  = 1'b0;
    sd_addr  = '0;
    sd_din   = '0;
    sd_wtbt  = '0;
    sd_rd    = 1'b0;
    sd_we    = 1'b0;
    fill_en  = 1'b0;
    wr_en    = 1'b0;
    unique case (state)
      S_HIT: begin
        cpu_ack  = 1'b1;
        cpu_dout = burst_word(line_data, word);
      end
      S_FILL_REQ, S_FILL_GUARD, S_FILL_WAIT: begin
        sd_addr = {cpu_addr[AW-1:3], 3'b000};
        sd_rd   = 1'b1;
        if (state == S_FILL_WAIT && sd_ready) begin
          sd_rd    = 1'b0;
          cpu_ack  = 1'b1;
          cpu_dout = burst_word(sd_dout, word);
          fill_en  = 1'b1;
        end
      end
      S_WR_REQ, S_WR_GUARD, S_WR_WAIT: begin
        sd_addr = cpu_addr;
        sd_din  = cpu_din;
        sd_wtbt = cpu_wtbt;
        sd_we   = 1'b1;
        if (state == S_WR_WAIT && sd_ready) begin
          sd_we   = 1'b0;
          cpu_ack = 1'b1;
          wr_en   = hit;
        end
      end
      default: ;
    endcase
  end

  sdram_line_store #(
    .LINE_BITS (LINE_BITS),
    .TAG_W     (TAG_W)
  ) u_store (
    .clk        (clk),
    .init       (init),
    .flush      (flush),
    .fill_en    (fill_en),
    .fill_idx   (idx),
    .fill_data  (sd_dout),
    .fill_tag   (tag),
    .fill_valid (~(flush_seen | flush)),
    .wr_en      (wr_en),
    .wr_idx     (idx),
    .wr_word    (word),
    .wr_be      (wr_be),
    .wr_data    (wr_data),
    .rd_idx     (idx),
    .rd_data    (line_data),
    .rd_tag     (line_tag),
    .rd_valid   (line_valid)
  );

endmodule
